ifetch_ctrl: RTL and testbench

Instruction-fetch controller on the consumer side of the fetch-PC register. Takes the current fetch address `pcfetch`, runs a request/ready handshake with variable-latency instruction memory, and delivers instruction plus PC+4 to the IF/ID boundary with a valid flag. It generates `stallf` back to the PC register, freezing the PC while memory is busy or decode is backed up. It also has a one-entry skid buffer so that no fetched word is lost.

---
 rtl/ifetch_ctrl.sv | 116 +++++++++++
 tb/tb_ifetch_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: memory request/ready handshake, IF/ID output
// registers, PC-freeze generation and a one-entry skid buffer for decode stalls.
module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0040_0030
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pcfetch,
  input  logic        stalld,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        stallf,
  output logic [31:0] instrd,
  output logic [31:0] pcplus4d,
  output logic        validd,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  // Handshake: a read completes on any cycle where mem_req && mem_ready are both
  // high at the rising edge; mem_ready is ignored whenever mem_req is low.
  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic [31:0] r_instrd;
  logic [31:0] r_pcplus4d;
  logic        r_validd;
  logic [31:0] r_skid_instr;
  logic [31:0] r_skid_pc4;
  logic [31:0] w_pc4;
  logic        w_accept;
  logic        w_decode_busy;

  assign w_pc4         = pcfetch + 32'd4;
  assign w_accept      = (r_state == S_FETCH) && mem_ready;
  assign w_decode_busy = stalld && r_validd;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (flush) begin
      w_next_state = S_FETCH;
    end else begin
      case (r_state)
        S_IDLE:  w_next_state = S_FETCH;
        S_FETCH: if (mem_ready && w_decode_busy) w_next_state = S_HOLD;
        S_HOLD:  if (!stalld) w_next_state = S_FETCH;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_req   = (r_state == S_FETCH);
    mem_addr  = pcfetch;
    stallf    = !reset && !flush &&
                ((r_state == S_IDLE) || (r_state == S_HOLD) ||
                 ((r_state == S_FETCH) && !mem_ready));
    dbg_state = r_state;
  end

  // A flush kills both the in-flight response and anything parked in the skid.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_instrd     <= 32'd0;
      r_pcplus4d   <= 32'd0;
      r_validd     <= 1'b0;
      r_skid_instr <= 32'd0;
      r_skid_pc4   <= 32'd0;
    end else if (flush) begin
      r_validd     <= 1'b0;
      r_skid_instr <= 32'd0;
      r_skid_pc4   <= 32'd0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_accept && !w_decode_busy) begin
            r_instrd   <= mem_rdata;
            r_pcplus4d <= w_pc4;
            r_validd   <= 1'b1;
          end else if (w_accept) begin
            r_skid_instr <= mem_rdata;
            r_skid_pc4   <= w_pc4;
          end else if (!stalld) begin
            r_validd <= 1'b0;
          end
        end
        S_HOLD: begin
          if (!stalld) begin
            r_instrd   <= r_skid_instr;
            r_pcplus4d <= r_skid_pc4;
            r_validd   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign instrd   = r_instrd;
  assign pcplus4d = r_pcplus4d;
  assign validd   = r_validd;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: startup, wait states, skid, flushes, wrap, reset.
module tb_ifetch_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] pcfetch;
  logic        stalld;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        stallf;
  logic [31:0] instrd;
  logic [31:0] pcplus4d;
  logic        validd;
  logic [1:0]  dbg_state;

  int checks;
  int failures;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  ifetch_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .pcfetch   (pcfetch),
    .stalld    (stalld),
    .flush     (flush),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .stallf    (stallf),
    .instrd    (instrd),
    .pcplus4d  (pcplus4d),
    .validd    (validd),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    pcfetch   = 32'h0040_0030;
    stalld    = 1'b0;
    flush     = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'h8C08_0000;

    // Reset / startup
    step();
    step();
    check("rst_validd", {31'd0, validd}, 32'd0);
    check("rst_instrd", instrd, 32'd0);
    check("rst_pc4", pcplus4d, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    reset = 1'b0;
    #1;
    check("idle_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    check("idle_stallf", {31'd0, stallf}, 32'd1);
    check("idle_mem_req", {31'd0, mem_req}, 32'd0);
    step();
    check("f0_mem_req", {31'd0, mem_req}, 32'd1);
    check("f0_mem_addr", mem_addr, 32'h0040_0030);
    check("f0_stallf", {31'd0, stallf}, 32'd0);
    check("f0_validd", {31'd0, validd}, 32'd0);
    step();
    check("f0_out_validd", {31'd0, validd}, 32'd1);
    check("f0_out_instr", instrd, 32'h8C08_0000);
    check("f0_out_pc4", pcplus4d, 32'h0040_0034);

    // Three wait states
    pcfetch   = 32'h0040_0034;
    mem_ready = 1'b0;
    #1;
    check("w1_stallf", {31'd0, stallf}, 32'd1);
    check("w1_addr", mem_addr, 32'h0040_0034);
    step();
    check("w2_validd", {31'd0, validd}, 32'd0);
    check("w2_stallf", {31'd0, stallf}, 32'd1);
    check("w2_addr", mem_addr, 32'h0040_0034);
    step();
    check("w3_stallf", {31'd0, stallf}, 32'd1);
    check("w3_addr", mem_addr, 32'h0040_0034);
    step();
    mem_ready = 1'b1;
    mem_rdata = 32'h0109_5020;
    #1;
    check("w_rdy_stallf", {31'd0, stallf}, 32'd0);
    step();
    check("w_out_validd", {31'd0, validd}, 32'd1);
    check("w_out_instr", instrd, 32'h0109_5020);
    check("w_out_pc4", pcplus4d, 32'h0040_0038);

    // Decode stall into skid
    pcfetch   = 32'h0040_0038;
    stalld    = 1'b1;
    mem_rdata = 32'h2009_0005;
    #1;
    check("sk_acc_stallf", {31'd0, stallf}, 32'd0);
    step();
    pcfetch = 32'h0040_003C;
    mem_rdata = 32'hDEAD_BEEF;
    #1;
    check("sk_state", {30'd0, dbg_state}, {30'd0, S_HOLD});
    check("sk_stallf", {31'd0, stallf}, 32'd1);
    check("sk_mem_req", {31'd0, mem_req}, 32'd0);
    check("sk_hold_instr", instrd, 32'h0109_5020);
    check("sk_hold_valid", {31'd0, validd}, 32'd1);
    step();
    check("sk_hold2_instr", instrd, 32'h0109_5020);
    check("sk_hold2_pc4", pcplus4d, 32'h0040_0038);
    stalld = 1'b0;
    mem_ready = 1'b0;
    #1;
    check("sk_rel_stallf", {31'd0, stallf}, 32'd1);
    step();
    check("sk_out_instr", instrd, 32'h2009_0005);
    check("sk_out_pc4", pcplus4d, 32'h0040_003C);
    check("sk_out_valid", {31'd0, validd}, 32'd1);
    check("sk_next_req", {31'd0, mem_req}, 32'd1);
    check("sk_next_addr", mem_addr, 32'h0040_003C);

    // Flush on second wait cycle
    step();
    check("fw_bubble", {31'd0, validd}, 32'd0);
    flush = 1'b1;
    #1;
    check("fw_stallf", {31'd0, stallf}, 32'd0);
    step();
    flush     = 1'b0;
    pcfetch   = 32'h0040_0100;
    mem_ready = 1'b1;
    mem_rdata = 32'hAAAA_0001;
    #1;
    check("fw_validd", {31'd0, validd}, 32'd0);
    check("fw_state", {30'd0, dbg_state}, {30'd0, S_FETCH});
    check("fw_req", {31'd0, mem_req}, 32'd1);
    check("fw_addr", mem_addr, 32'h0040_0100);
    step();
    check("fw_out_instr", instrd, 32'hAAAA_0001);
    check("fw_out_pc4", pcplus4d, 32'h0040_0104);
    check("fw_out_valid", {31'd0, validd}, 32'd1);

    // Flush with skid full
    pcfetch   = 32'h0040_0104;
    stalld    = 1'b1;
    mem_rdata = 32'hBBBB_0002;
    step();
    check("fh_state", {30'd0, dbg_state}, {30'd0, S_HOLD});
    flush = 1'b1;
    #1;
    check("fh_stallf", {31'd0, stallf}, 32'd0);
    step();
    flush     = 1'b0;
    stalld    = 1'b0;
    pcfetch   = 32'hFFFF_FFFC;
    mem_rdata = 32'hCCCC_0003;
    #1;
    check("fh_validd", {31'd0, validd}, 32'd0);
    check("fh_state2", {30'd0, dbg_state}, {30'd0, S_FETCH});
    check("fh_instr_kept", instrd, 32'hAAAA_0001);

    // PC+4 wrap
    check("wr_addr", mem_addr, 32'hFFFF_FFFC);
    step();
    check("wr_pc4", pcplus4d, 32'h0000_0000);
    check("wr_instr", instrd, 32'hCCCC_0003);
    check("wr_valid", {31'd0, validd}, 32'd1);

    // Flush coinciding with mem_ready drops the response
    pcfetch   = 32'h0000_0000;
    flush     = 1'b1;
    mem_rdata = 32'hDDDD_0004;
    #1;
    check("fr_stallf", {31'd0, stallf}, 32'd0);
    step();
    flush = 1'b0;
    mem_ready = 1'b0;
    #1;
    check("fr_validd", {31'd0, validd}, 32'd0);
    check("fr_instr", instrd, 32'hCCCC_0003);

    // Reset mid-transaction
    reset     = 1'b1;
    mem_ready = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("mr_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    check("mr_instr", instrd, 32'd0);
    check("mr_pc4", pcplus4d, 32'd0);
    check("mr_validd", {31'd0, validd}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
